// File: rtl/panel_io_pkg.sv
// Shared constants for the panel I/O block: seven-segment patterns (active-low, gfedcba)
// and the blank pattern used while in reset.
package panel_io_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  localparam logic [6:0] SEG_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

endpackage

// File: rtl/db_channel.sv
// One debounced button: 2-flop synchronizer, tick-driven persistence counter and accepted level.
module db_channel
  import panel_io_pkg::*;
#(
  parameter int DB_TICKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic din,
  output logic state
);

  localparam int CW = $clog2(DB_TICKS + 1);

  logic [1:0]    sync;
  logic [CW-1:0] count;

  // The count is cleared on acceptance, so it never climbs past DB_TICKS-1 and cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= '0;
      count <= '0;
      state <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == state) begin
        count <= '0;
      end else if (tick) begin
        if (count >= CW'(DB_TICKS - 1)) begin
          state <= sync[1];
          count <= '0;
        end else begin
          count <= count + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/panel_io.sv
// Front-panel I/O: tick divider, NBTN debounced buttons and a registered hex seven-segment decoder.
// Defining PANEL_IO_RISE_EN enables the btn_rise edge detector; otherwise btn_rise is tied low.
module panel_io
  import panel_io_pkg::*;
#(
  parameter int CLK_HZ   = 100_000_000,
  parameter int TICK_HZ  = 1000,
  parameter int DB_TICKS = 10,
  parameter int NBTN     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NBTN-1:0] btn_in,
  output logic [NBTN-1:0] btn_state,
  output logic [NBTN-1:0] btn_rise,
  output logic            tick_1khz,
  output logic            clk_1khz,
  input  logic [3:0]      bin,
  output logic [6:0]      seg
);

  localparam int DIV   = CLK_HZ / TICK_HZ;
  localparam int CNT_W = $clog2(DIV);

  logic [CNT_W-1:0] div_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (div_cnt == CNT_W'(DIV - 1)) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Both outputs decode the counter directly; clk_1khz is an output only, never used as a clock here.
  assign tick_1khz = (div_cnt == CNT_W'(DIV - 1));
  assign clk_1khz  = (div_cnt < CNT_W'(DIV / 2));

  for (genvar i = 0; i < NBTN; i++) begin : g_btn
    db_channel #(
      .DB_TICKS(DB_TICKS)
    ) u_db (
      .clk  (clk),
      .rst  (rst),
      .tick (tick_1khz),
      .din  (btn_in[i]),
      .state(btn_state[i])
    );
  end

`ifdef PANEL_IO_RISE_EN
  logic [NBTN-1:0] state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else begin
      state_q <= btn_state;
    end
  end

  assign btn_rise = btn_state & ~state_q;
`else
  assign btn_rise = '0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg <= SEG_BLANK;
    end else begin
      seg <= SEG_LUT[bin];
    end
  end

endmodule

// File: tb/tb_panel_io.sv
// Directed self-checking bench for panel_io with DIV=10, DB_TICKS=3, NBTN=4.
// Honours PANEL_IO_RISE_EN when predicting btn_rise.
module tb_panel_io;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_state;
  logic [3:0] btn_rise;
  logic       tick_1khz;
  logic       clk_1khz;
  logic [3:0] bin;
  logic [6:0] seg;

  int checks   = 0;
  int failures = 0;
  int tick_seen;

  logic [6:0] seg_exp [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

`ifdef PANEL_IO_RISE_EN
  localparam bit RISE_ON = 1'b1;
`else
  localparam bit RISE_ON = 1'b0;
`endif

  panel_io #(
    .CLK_HZ  (1000),
    .TICK_HZ (100),
    .DB_TICKS(3),
    .NBTN    (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .btn_in   (btn_in),
    .btn_state(btn_state),
    .btn_rise (btn_rise),
    .tick_1khz(tick_1khz),
    .clk_1khz (clk_1khz),
    .bin      (bin),
    .seg      (seg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Moves to just after the next edge on which the debounce counters see a tick.
  task automatic wait_tick_edge();
    bit got = 1'b0;
    for (int n = 0; n < 25 && !got; n++) begin
      if (tick_1khz === 1'b1) got = 1'b1;
      step();
    end
    check_output("tick_wait", got, 1);
  endtask

  task automatic apply_stimulus(input logic [3:0] btn, input logic [3:0] digit);
    btn_in = btn;
    bin    = digit;
  endtask

  initial begin
    rst = 1'b1;
    apply_stimulus(4'b0000, 4'h0);
    repeat (3) step();
    check_output("rst_seg", seg, 7'b1111111);
    check_output("rst_tick", tick_1khz, 1'b0);
    check_output("rst_clk1k", clk_1khz, 1'b1);
    check_output("rst_state", btn_state, 4'b0000);
    check_output("rst_rise", btn_rise, 4'b0000);

    // Divider: counter value equals edges since release, mod 10
    rst = 1'b0;
    tick_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (tick_1khz === 1'b1) tick_seen++;
      check_output("div_tick", tick_1khz, (k % 10) == 9);
      check_output("div_clk1k", clk_1khz, (k % 10) < 5);
    end
    check_output("div_tick_count", tick_seen, 4);

    // Decoder sweep with one-cycle latency
    for (int d = 0; d < 16; d++) begin
      bin = 4'(d);
      if (d == 8) check_output("seg_latency", seg, 7'b1111000);
      step();
      check_output("seg_decode", seg, seg_exp[d]);
    end
    check_output("seg_8", seg_exp[8], 7'b0000000);

    // Steady press on channel 0
    apply_stimulus(4'b0001, 4'hF);
    repeat (2) step();
    wait_tick_edge();
    wait_tick_edge();
    check_output("b0_before", btn_state, 4'b0000);
    wait_tick_edge();
    check_output("b0_state", btn_state, 4'b0001);
    check_output("b0_rise", btn_rise, RISE_ON ? 4'b0001 : 4'b0000);
    for (int k = 0; k < 15; k++) begin
      step();
      check_output("b0_rise_once", btn_rise, 4'b0000);
    end
    check_output("b0_held", btn_state, 4'b0001);
    apply_stimulus(4'b0000, 4'hF);
    repeat (2) step();
    repeat (3) wait_tick_edge();
    check_output("b0_release", btn_state, 4'b0000);

    // Short glitch on channel 1
    apply_stimulus(4'b0010, 4'hF);
    repeat (2) step();
    wait_tick_edge();
    wait_tick_edge();
    apply_stimulus(4'b0000, 4'hF);
    for (int k = 0; k < 40; k++) begin
      step();
      check_output("b1_state", btn_state, 4'b0000);
      check_output("b1_rise", btn_rise, 4'b0000);
    end

    // All four pressed together
    apply_stimulus(4'b1111, 4'hF);
    repeat (2) step();
    wait_tick_edge();
    wait_tick_edge();
    check_output("all_before", btn_state, 4'b0000);
    wait_tick_edge();
    check_output("all_state", btn_state, 4'b1111);
    check_output("all_rise", btn_rise, RISE_ON ? 4'b1111 : 4'b0000);
    apply_stimulus(4'b0000, 4'hF);
    repeat (2) step();
    repeat (3) wait_tick_edge();
    check_output("all_release", btn_state, 4'b0000);

    // Reset in the middle of a debounce on channel 2
    apply_stimulus(4'b0100, 4'hF);
    repeat (2) step();
    wait_tick_edge();
    wait_tick_edge();
    check_output("seg_pre_rst", seg, 7'b0001110);
    rst = 1'b1;
    #1;
    check_output("mid_rst_seg", seg, 7'b1111111);
    check_output("mid_rst_clk1k", clk_1khz, 1'b1);
    check_output("mid_rst_tick", tick_1khz, 1'b0);
    check_output("mid_rst_state", btn_state, 4'b0000);
    check_output("mid_rst_rise", btn_rise, 4'b0000);
    repeat (2) step();
    rst = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      step();
      if (k == 1) check_output("post_rst_seg", seg, 7'b0001110);
      if (k == 29) check_output("b2_not_yet", btn_state, 4'b0000);
      if (k == 30) begin
        check_output("b2_state", btn_state, 4'b0100);
        check_output("b2_rise", btn_rise, RISE_ON ? 4'b0100 : 4'b0000);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
